// File: rtl/gate_unit_pkg.sv
// Shared definitions for the gate_unit_arbiter slice: opcode values and FSM state encoding.
package gate_unit_pkg;

  localparam logic [1:0] OP_NOT = 2'd0;
  localparam logic [1:0] OP_AND = 2'd1;
  localparam logic [1:0] OP_OR  = 2'd2;
  localparam logic [1:0] OP_XOR = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

endpackage

// File: rtl/gate_unit_arbiter_rr_pick.sv
// Combinational round-robin picker: first set bit of req searching upward from last+1.
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    last,
  output logic [ID_W-1:0]    winner,
  output logic               found
);

  localparam logic [ID_W:0] NUM_REQ_W = (ID_W+1)'(NUM_REQ);

  logic [ID_W:0] cand;

  // NUM_REQ need not be a power of two, so wrap by compare-and-subtract.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    cand   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = {1'b0, last} + (ID_W+1)'(k);
      if (cand >= NUM_REQ_W) begin
        cand = cand - NUM_REQ_W;
      end
      if (!found && req[cand[ID_W-1:0]]) begin
        winner = cand[ID_W-1:0];
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/gate_unit_arbiter.sv
// Round-robin sequencer sharing one NOT/AND/OR/XOR gate + DFF stage among NUM_REQ requesters.
// Define ARB_LOCK_EN to add the lock port and bounded re-grant to a locking requester.
module gate_unit_arbiter
  import gate_unit_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int ID_W     = $clog2(NUM_REQ)
`ifdef ARB_LOCK_EN
  , parameter int MAX_LOCK = 3
`endif
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [2*NUM_REQ-1:0] op,
  input  logic [NUM_REQ-1:0]   opa,
  input  logic [NUM_REQ-1:0]   opb,
`ifdef ARB_LOCK_EN
  input  logic [NUM_REQ-1:0]   lock,
`endif
  output logic [NUM_REQ-1:0]   gnt,
  output logic                 rsp_valid,
  output logic [ID_W-1:0]      rsp_id,
  output logic                 rsp_data,
  output logic                 busy,
  output logic [1:0]           dbg_state
);

  localparam logic [ID_W-1:0] LAST_RST = ID_W'(NUM_REQ - 1);

  state_e               state_q, state_d;
  logic [NUM_REQ-1:0]   gnt_q, gnt_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0]      rsp_id_q, rsp_id_d;
  logic                 rsp_data_q, rsp_data_d;
  logic                 busy_q, busy_d;
  logic [ID_W-1:0]      last_q, last_d;
  logic [1:0]           op_q, op_d;
  logic                 a_q, a_d;
  logic                 b_q, b_d;

  logic [ID_W-1:0]      rr_winner;
  logic                 rr_found;
  logic [ID_W-1:0]      pick;
  logic                 pick_vld;
  logic                 gate_out;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_pick (
    .req    (req),
    .last   (last_q),
    .winner (rr_winner),
    .found  (rr_found)
  );

`ifdef ARB_LOCK_EN
  localparam int              LOCK_W     = (MAX_LOCK < 1) ? 1 : $clog2(MAX_LOCK + 1);
  localparam logic [LOCK_W-1:0] LOCK_MAX = LOCK_W'(MAX_LOCK);

  logic [LOCK_W-1:0] lock_cnt_q, lock_cnt_d;
  logic              lock_hold;

  // A locking owner of the previous grant keeps the unit for at most MAX_LOCK extra ops.
  always_comb begin
    lock_hold = req[last_q] && lock[last_q] && (lock_cnt_q < LOCK_MAX);
    pick      = lock_hold ? last_q : rr_winner;
    pick_vld  = lock_hold || rr_found;
  end

  always_comb begin
    lock_cnt_d = lock_cnt_q;
    if (state_q == ST_IDLE) begin
      if (req == '0) begin
        lock_cnt_d = '0;
      end else if (lock_hold) begin
        lock_cnt_d = lock_cnt_q + LOCK_W'(1);
      end else if (rr_winner != last_q) begin
        lock_cnt_d = '0;
      end
    end
  end
`else
  always_comb begin
    pick     = rr_winner;
    pick_vld = rr_found;
  end
`endif

  // Shared gate stage; evaluates only the latched operands so live inputs cannot disturb it.
  always_comb begin
    gate_out = 1'b0;
    case (op_q)
      OP_NOT:  gate_out = ~a_q;
      OP_AND:  gate_out = a_q & b_q;
      OP_OR:   gate_out = a_q | b_q;
      OP_XOR:  gate_out = a_q ^ b_q;
      default: gate_out = 1'b0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    gnt_d       = '0;
    rsp_valid_d = 1'b0;
    rsp_id_d    = rsp_id_q;
    rsp_data_d  = rsp_data_q;
    last_d      = last_q;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_vld) begin
          gnt_d[pick] = 1'b1;
          last_d      = pick;
          op_d        = op[{pick, 1'b0} +: 2];
          a_d         = opa[pick];
          b_d         = opb[pick];
          state_d     = ST_EXEC;
        end
      end
      ST_EXEC: begin
        rsp_data_d  = gate_out;
        rsp_id_d    = last_q;
        rsp_valid_d = 1'b1;
        state_d     = ST_RESP;
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      gnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_data_q  <= 1'b0;
      busy_q      <= 1'b0;
      last_q      <= LAST_RST;
      op_q        <= 2'd0;
      a_q         <= 1'b0;
      b_q         <= 1'b0;
`ifdef ARB_LOCK_EN
      lock_cnt_q  <= '0;
`endif
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
      busy_q      <= busy_d;
      last_q      <= last_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
`ifdef ARB_LOCK_EN
      lock_cnt_q  <= lock_cnt_d;
`endif
    end
  end

  assign gnt       = gnt_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;
  assign busy      = busy_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_gate_unit_arbiter.sv
// Directed bench for gate_unit_arbiter: driver tasks push expected grants/results, a monitor pops and compares.
// Handshake: gnt is a one-cycle pulse; the requester drops req in the cycle after gnt; rsp_valid follows gnt by one cycle.
module tb_gate_unit_arbiter;
  import gate_unit_pkg::*;

  localparam int N  = 4;
  localparam int IW = 2;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [N-1:0]   req;
  logic [2*N-1:0] op;
  logic [N-1:0]   opa, opb;
  logic [N-1:0]   gnt;
  logic           rsp_valid;
  logic [IW-1:0]  rsp_id;
  logic           rsp_data;
  logic           busy;
  logic [1:0]     dbg_state;
`ifdef ARB_LOCK_EN
  logic [N-1:0]   lock;
  logic [2:0]     r3_lock;
`endif

  logic [2:0] r3_req, r3_opa, r3_opb, r3_gnt;
  logic [5:0] r3_op;
  logic       r3_rsp_valid, r3_rsp_data, r3_busy;
  logic [1:0] r3_rsp_id, r3_dbg;

  gate_unit_arbiter #(.NUM_REQ(N)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .op        (op),
    .opa       (opa),
    .opb       (opb),
`ifdef ARB_LOCK_EN
    .lock      (lock),
`endif
    .gnt       (gnt),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  gate_unit_arbiter #(.NUM_REQ(3)) u_dut3 (
    .clk       (clk),
    .rst       (rst),
    .req       (r3_req),
    .op        (r3_op),
    .opa       (r3_opa),
    .opb       (r3_opb),
`ifdef ARB_LOCK_EN
    .lock      (r3_lock),
`endif
    .gnt       (r3_gnt),
    .rsp_valid (r3_rsp_valid),
    .rsp_id    (r3_rsp_id),
    .rsp_data  (r3_rsp_data),
    .busy      (r3_busy),
    .dbg_state (r3_dbg)
  );

  // scoreboard
  logic [N-1:0] exp_gnt_q[$];
  logic [IW:0]  exp_q[$];
  int checks = 0;
  int errors = 0;
  int gnt_seen = 0;
  int rsp_seen = 0;
  logic mon_on = 1'b0;
  logic prev_gnt = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s act=timeout exp=event", name);
  endtask

  always @(posedge clk) begin
    #1;
    if (mon_on) begin
      if (gnt !== '0) begin
        gnt_seen++;
        if (exp_gnt_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL gnt_unexpected act=%b exp=none", gnt);
        end else begin
          chk("gnt", 32'(gnt), 32'(exp_gnt_q.pop_front()));
        end
      end
      if (rsp_valid !== 1'b0) begin
        rsp_seen++;
        chk("rsp_latency", 32'(prev_gnt), 32'd1);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rsp_unexpected act=%0d/%0d exp=none", rsp_id, rsp_data);
        end else begin
          chk("rsp_id_data", 32'({rsp_id, rsp_data}), 32'(exp_q.pop_front()));
        end
      end
      chk("busy", 32'(busy), 32'((|gnt) | rsp_valid));
      prev_gnt = |gnt;
    end
  end

  // driver tasks
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    req = '0;
    r3_req = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_idle();
    int i;
    i = 0;
    @(negedge clk);
    while (busy !== 1'b0 && i < 50) begin
      @(negedge clk);
      i++;
    end
    if (busy !== 1'b0) fail_now("idle_wait");
  endtask

  task automatic wait_grants(input int target);
    int i;
    i = 0;
    while (gnt_seen < target && i < 100) begin
      @(negedge clk);
      i++;
    end
    if (gnt_seen < target) fail_now("grant_wait");
  endtask

  task automatic wait_rsps(input int target);
    int i;
    i = 0;
    while (rsp_seen < target && i < 100) begin
      @(negedge clk);
      i++;
    end
    if (rsp_seen < target) fail_now("rsp_wait");
  endtask

  task automatic issue_one(input int id, input logic [1:0] opc, input logic a, input logic b,
                           input logic exp_d);
    logic [N-1:0] m;
    int g, r;
    wait_idle();
    m = '0;
    m[id] = 1'b1;
    op[2*id +: 2] = opc;
    opa[id] = a;
    opb[id] = b;
    req = m;
    exp_gnt_q.push_back(m);
    exp_q.push_back({IW'(id), exp_d});
    g = gnt_seen + 1;
    r = rsp_seen + 1;
    wait_grants(g);
    req = '0;
    wait_rsps(r);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1);
  end

  initial begin
    int g, r;
    rst = 1'b1;
    req = '0;
    op = '0;
    opa = '0;
    opb = '0;
    r3_req = '0;
    r3_op = '0;
    r3_opa = '0;
    r3_opb = '0;
`ifdef ARB_LOCK_EN
    lock = '0;
    r3_lock = '0;
`endif
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // reset state
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_id", 32'(rsp_id), 32'd0);
    chk("rst_rsp_data", 32'(rsp_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    mon_on = 1'b1;

    // single request: AND 1,1 on requester 0, latency t+1 / t+2
    op[1:0] = OP_AND;
    opa[0] = 1'b1;
    opb[0] = 1'b1;
    req = 4'b0001;
    exp_gnt_q.push_back(4'b0001);
    exp_q.push_back({2'd0, 1'b1});
    @(posedge clk);
    #2;
    chk("lat_gnt", 32'(gnt_seen), 32'd1);
    @(negedge clk);
    req = '0;
    @(posedge clk);
    #2;
    chk("lat_rsp", 32'(rsp_seen), 32'd1);

    // opcode sweep on requester 2
    issue_one(2, OP_NOT, 1'b0, 1'b1, 1'b1);
    issue_one(2, OP_OR,  1'b0, 1'b0, 1'b0);
    issue_one(2, OP_XOR, 1'b1, 1'b0, 1'b1);
    issue_one(2, OP_XOR, 1'b1, 1'b1, 1'b0);
    issue_one(2, OP_AND, 1'b1, 1'b0, 1'b0);

    // rotation from reset pointer, all four held
    do_reset();
    op  = {OP_XOR, OP_OR, OP_AND, OP_NOT};
    opa = 4'b0110;
    opb = 4'b1100;
    req = 4'b1111;
    exp_gnt_q.push_back(4'b0001); exp_q.push_back({2'd0, 1'b1});
    exp_gnt_q.push_back(4'b0010); exp_q.push_back({2'd1, 1'b0});
    exp_gnt_q.push_back(4'b0100); exp_q.push_back({2'd2, 1'b1});
    exp_gnt_q.push_back(4'b1000); exp_q.push_back({2'd3, 1'b1});
    exp_gnt_q.push_back(4'b0001); exp_q.push_back({2'd0, 1'b1});
    g = gnt_seen + 5;
    r = rsp_seen + 5;
    wait_grants(g);
    req = '0;
    wait_rsps(r);

    // wrap with sparse requests: last=2, req=1001 -> 3 then 0
    issue_one(2, OP_OR, 1'b0, 1'b1, 1'b1);
    wait_idle();
    op[7:6] = OP_NOT; opa[3] = 1'b0;
    op[1:0] = OP_XOR; opa[0] = 1'b1; opb[0] = 1'b1;
    req = 4'b1001;
    exp_gnt_q.push_back(4'b1000); exp_q.push_back({2'd3, 1'b1});
    exp_gnt_q.push_back(4'b0001); exp_q.push_back({2'd0, 1'b0});
    g = gnt_seen + 2;
    r = rsp_seen + 2;
    wait_grants(g);
    req = '0;
    wait_rsps(r);

    // reset during EXEC discards the in-flight op
    wait_idle();
    op[5:4] = OP_AND; opa[2] = 1'b1; opb[2] = 1'b1;
    req = 4'b0100;
    exp_gnt_q.push_back(4'b0100);
    g = gnt_seen + 1;
    r = rsp_seen;
    wait_grants(g);
    chk("mid_state_exec", 32'(dbg_state), 32'(ST_EXEC));
    rst = 1'b1;
    req = '0;
    @(posedge clk);
    #2;
    chk("mid_gnt", 32'(gnt), 32'd0);
    chk("mid_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("mid_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_no_rsp", 32'(rsp_seen), 32'(r));
    issue_one(1, OP_XOR, 1'b1, 1'b1, 1'b0);

    // lock behaviour: req=0011, lock=0001
    do_reset();
    op[1:0] = OP_AND; opa[0] = 1'b1; opb[0] = 1'b1;
    op[3:2] = OP_OR;  opa[1] = 1'b0; opb[1] = 1'b0;
`ifdef ARB_LOCK_EN
    lock = 4'b0001;
    for (int i = 0; i < 4; i++) begin
      exp_gnt_q.push_back(4'b0001); exp_q.push_back({2'd0, 1'b1});
    end
    exp_gnt_q.push_back(4'b0010); exp_q.push_back({2'd1, 1'b0});
    g = gnt_seen + 5;
    r = rsp_seen + 5;
`else
    for (int i = 0; i < 2; i++) begin
      exp_gnt_q.push_back(4'b0001); exp_q.push_back({2'd0, 1'b1});
      exp_gnt_q.push_back(4'b0010); exp_q.push_back({2'd1, 1'b0});
    end
    g = gnt_seen + 4;
    r = rsp_seen + 4;
`endif
    req = 4'b0011;
    wait_grants(g);
    req = '0;
`ifdef ARB_LOCK_EN
    lock = '0;
`endif
    wait_rsps(r);

    // NUM_REQ=3: grant 2 then wrap to 0 on req=101
    do_reset();
    r3_op  = {OP_AND, OP_AND, OP_AND};
    r3_opa = 3'b111;
    r3_opb = 3'b111;
    r3_req = 3'b100;
    @(posedge clk);
    #2;
    chk("n3_gnt_first", 32'(r3_gnt), 32'b100);
    @(negedge clk);
    r3_req = 3'b101;
    repeat (3) @(posedge clk);
    #2;
    chk("n3_gnt_wrap", 32'(r3_gnt), 32'b001);
    @(posedge clk);
    #2;
    chk("n3_rsp_valid", 32'(r3_rsp_valid), 32'd1);
    chk("n3_rsp_id", 32'(r3_rsp_id), 32'd0);
    chk("n3_rsp_data", 32'(r3_rsp_data), 32'd1);
    @(negedge clk);
    r3_req = '0;

    // report
    wait_idle();
    repeat (4) @(negedge clk);
    chk("exp_gnt_drained", 32'(exp_gnt_q.size()), 32'd0);
    chk("exp_rsp_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
